// File: rtl/crc_pkg.sv
// Shared CRC definitions: default polynomial/seed shared with the crc2
// generator so both ends of the link stay in step, plus checker FSM encoding.
package crc_pkg;

    localparam int         CRC_WIDTH = 8;
    localparam logic [7:0] CRC_TAPS  = 8'b0100_0100;
    localparam logic [7:0] CRC_SEED  = 8'hD8;

    // Checker FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial step of the CRC LFSR: shifts right, the feedback bit enters at
// the MSB and is folded into every tap position. Purely combinational.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS
) (
    input  logic [WIDTH-1:0] lfsr,
    input  logic             d,
    output logic [WIDTH-1:0] lfsr_next
);

    logic fb;

    assign fb = d ^ lfsr[0];
    assign lfsr_next[WIDTH-1] = fb;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign lfsr_next[gi] = lfsr[gi+1] ^ (TAPS[gi] & fb);
        end
    endgenerate

endmodule

// File: rtl/crc_checker.sv
// Receive-side serial CRC checker. Recomputes the CRC over the data phase,
// compares it LSB-first against the trailing received CRC and reports the
// frame verdict with a one-cycle done pulse plus sticky ok/err flags.
// WIDTH must be at least 2 (the handover cycle always leaves bits to check).
module crc_checker
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS,
    parameter logic [WIDTH-1:0] SEED  = CRC_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             data_active,
    input  logic             crc_valid,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             frame_err,
    output logic [WIDTH-1:0] calc_crc
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] calc_q, calc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             ferr_q, ferr_d;

    logic [WIDTH-1:0] step_in;
    logic [WIDTH-1:0] step_out;
    logic             bit_mis;
    logic             mis_now;

    // A new frame always starts from the seed, so the first data bit is
    // absorbed on top of SEED rather than on whatever the LFSR last held.
    assign step_in = (state_q == ST_IDLE) ? SEED : lfsr_q;
    assign bit_mis = ser_in ^ shift_q[0];
    assign mis_now = mis_q | bit_mis;

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .lfsr      (step_in),
        .d         (ser_in),
        .lfsr_next (step_out)
    );

    // Frame FSM: data absorption, optional idle gap, bit-serial CRC compare
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        shift_d = shift_q;
        calc_d  = calc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;
        ferr_d  = ferr_q;

        case (state_q)
            ST_IDLE: begin
                if (data_active) begin
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    ferr_d  = 1'b0;
                    mis_d   = 1'b0;
                    cnt_d   = '0;
                    lfsr_d  = step_out;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_active) begin
                    // Data wins over a simultaneous crc_valid
                    lfsr_d = step_out;
                end else if (crc_valid) begin
                    // Zero-gap handover: first CRC bit checked against lfsr
                    calc_d  = lfsr_q;
                    mis_d   = ser_in ^ lfsr_q[0];
                    shift_d = lfsr_q >> 1;
                    cnt_d   = CW'(1);
                    state_d = ST_CHECK;
                end else begin
                    calc_d  = lfsr_q;
                    shift_d = lfsr_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // New data before any CRC bit is a protocol violation; it
                // takes priority over a coincident crc_valid.
                if (data_active) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    ferr_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (crc_valid) begin
                    mis_d   = bit_mis;
                    shift_d = shift_q >> 1;
                    cnt_d   = CW'(1);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (data_active || !crc_valid) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    ferr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    mis_d   = mis_now;
                    if (cnt_q == LAST_CNT) begin
                        // Verdict includes the bit compared this cycle
                        done_d  = 1'b1;
                        ok_d    = ~mis_now;
                        err_d   = mis_now;
                        ferr_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                lfsr_d  = SEED;
                cnt_d   = '0;
                mis_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            shift_q <= '0;
            calc_q  <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            shift_q <= shift_d;
            calc_q  <= calc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    assign done      = done_q;
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign frame_err = ferr_q;
    assign calc_crc  = calc_q;

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Receive-side companion to the serial CRC generator (crc2).
- Takes the same serial stream the generator emits: a data phase (LSB-first, qualified by `data_active`), then the WIDTH-bit CRC (LSB-first, qualified by `crc_valid`).
- Recomputes the CRC over the data phase, compares it bit-serially against the received CRC, and reports pass/fail once per frame.
- Sits between the UART RX deserialiser path and the ALU command decoder.

Parameters:
- WIDTH, 8, CRC/LFSR width in bits.
- TAPS, 8'b0100_0100, feedback tap mask; bit i set means fb is XORed into lfsr_next[i].
- SEED, 8'hD8, LFSR load value at the start of each frame.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ser_in  in  1  serial bit: data during data phase, received CRC during check phase.
- data_active  in  1  high for each data bit of the frame.
- crc_valid  in  1  high for each received CRC bit.
- done  out  1  one-cycle pulse marking frame result valid.
- crc_ok  out  1  held high from done until next frame start if the CRC matched.
- crc_err  out  1  held high from done until next frame start if the CRC mismatched or the frame aborted.
- frame_err  out  1  held high with crc_err when the abort was a protocol violation.
- calc_crc  out  WIDTH  computed CRC, frozen at end of data phase.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State IDLE; lfsr=SEED; bit count=0.
  - done, crc_ok, crc_err, frame_err all 0; calc_crc=0.
- LFSR step, per data bit d:
  - fb = d ^ lfsr[0]
  - lfsr_next[WIDTH-1] = fb
  - lfsr_next[i] = lfsr[i+1] ^ (TAPS[i] & fb) for i < WIDTH-1
- IDLE:
  - data_active=1 starts a frame: clear crc_ok/crc_err/frame_err; lfsr = SEED stepped with ser_in (the first bit is absorbed this cycle); go to DATA.
  - crc_valid alone is ignored.
- DATA:
  - data_active=1: step the LFSR; data length is unbounded, minimum 1.
  - data_active=0 and crc_valid=0: go to WAIT; calc_crc <= lfsr.
  - data_active=0 and crc_valid=1: calc_crc <= lfsr; compare ser_in with lfsr[0]; count=1; go to CHECK. A zero-gap handover is legal.
  - data_active=1 and crc_valid=1: data wins; crc_valid is ignored.
- WAIT:
  - crc_valid=1: compare the first bit; go to CHECK.
  - data_active=1: abort.
  - Idle gap length is unbounded.
- CHECK:
  - Each crc_valid=1 cycle compares ser_in against the shifting copy of calc_crc (LSB first) and ORs any mismatch into a sticky flag; count increments.
  - After the WIDTH-th bit, go to DONE.
- Abort conditions in CHECK:
  - crc_valid=0 before WIDTH bits, or data_active=1 at any point.
  - On abort: go to DONE with frame_err=1 and crc_err=1.
- DONE (one cycle):
  - done=1.
  - crc_ok = ~mismatch & ~frame_err.
  - crc_err = ~crc_ok.
  - Return to IDLE.
- Latency: done asserts the cycle after the last CRC bit is sampled.
- Back-to-back frames: data_active may rise in the DONE cycle. It is not sampled there; the upstream must leave at least one gap cycle after done before the next data_active.
- rst mid-frame: immediate return to IDLE and all outputs cleared; no done pulse.

Decomposition:
- Shared package crc_pkg holds:
  - WIDTH, TAPS and SEED defaults, shared with crc2 so both ends cannot diverge.
  - State encoding: IDLE, DATA, WAIT, CHECK, DONE.
- Natural sub-module: crc_lfsr_step, a combinational next-state function (lfsr, d) -> lfsr_next.
  - Reused by crc2.
  - Instantiated once here.

Test Plan:
- Data 8'h00, then CRC 8'h14 (LSB-first 0,0,1,0,1,0,0,0), zero-gap handover -> calc_crc=8'h14; done one cycle after the 8th CRC bit; crc_ok=1, crc_err=0.
- Same frame with received CRC 8'h15 -> done; crc_ok=0, crc_err=1, frame_err=0.
- Data 8'h00, 3 idle cycles, CRC 8'h14 -> crc_ok=1 (WAIT state exercised).
- Data 8'h00, crc_valid for only 5 bits, then low -> done on the next cycle; crc_err=1, frame_err=1.
- rst=1 during the 4th data bit, then a full valid frame 8'h00/8'h14 -> no done from the aborted frame; second frame crc_ok=1 (seed reloaded).
- Compare all 10 DATA_h.txt/Expec_Out_h.txt vectors against the crc2 output looped back, with a 1-cycle gap after each done -> 10 done pulses, all crc_ok=1.
